// File: rtl/tone_period_meter.sv
// Half-period meter for an asynchronous square wave: synchronizes the input, times the
// interval between edges in clk_i cycles, locks on consistent runs and flags signal loss.
module tone_period_meter #(
    parameter int CNT_W          = 22,
    parameter int TOL            = 64,
    parameter int LOCK_CNT       = 4,
    parameter int TIMEOUT_CYCLES = 4_000_000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             tone_i,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0]   TOL_VAL     = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_VAL    = 4'(LOCK_CNT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] prev;
    logic [3:0]       match;
    logic             have_prev;

    logic tone_p0;
    logic tone_p1;
    logic tone_p2;
    logic edge_p3;

    logic is_match;
    logic timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        logic signed [CNT_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[CNT_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

    // Stage p0/p1: synchronizer, p2: history, p3: registered edge pulse (either polarity).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tone_p0 <= 1'b0;
            tone_p1 <= 1'b0;
            tone_p2 <= 1'b0;
            edge_p3 <= 1'b0;
        end else begin
            tone_p0 <= tone_i;
            tone_p1 <= tone_p0;
            tone_p2 <= tone_p1;
            edge_p3 <= tone_p1 ^ tone_p2;
        end
    end

    // The measurement m is the counter value in the cycle the edge pulse is high.
    assign is_match    = (abs_diff(cnt, prev) <= TOL_VAL);
    assign timeout_hit = (cnt == TIMEOUT_VAL) && !edge_p3;

    // Stage p4: measurement FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            prev      <= '0;
            match     <= '0;
            have_prev <= 1'b0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            locked_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else if (!en_i) begin
            state     <= IDLE;
            cnt       <= '0;
            prev      <= '0;
            match     <= '0;
            have_prev <= 1'b0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            locked_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            cnt     <= edge_p3 ? CNT_W'(1) : sat_inc(cnt);
            if (edge_p3) begin
                timeout_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (edge_p3) begin
                        have_prev <= 1'b0;
                        match     <= '0;
                        state     <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_p3) begin
                        prev      <= cnt;
                        have_prev <= 1'b1;
                        if (!have_prev || !is_match) begin
                            match <= '0;
                        end else if (match + 4'd1 == LOCK_VAL) begin
                            match    <= LOCK_VAL;
                            period_o <= cnt;
                            valid_o  <= 1'b1;
                            locked_o <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            match <= match + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (edge_p3) begin
                        prev <= cnt;
                        if (is_match) begin
                            period_o <= cnt;
                            valid_o  <= 1'b1;
                        end else begin
                            locked_o <= 1'b0;
                            match    <= '0;
                            state    <= MEASURE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // timeout_hit excludes edge cycles, so this never overrides an edge decision.
            if (state != IDLE && timeout_hit) begin
                timeout_o <= 1'b1;
                locked_o  <= 1'b0;
                period_o  <= '0;
                match     <= '0;
                state     <= WAIT_EDGE;
            end
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter: an edge-level model predicts the outputs for each
// tone transition, queued with their due cycle and compared cycle by cycle.
module tb_tone_period_meter;

    localparam int CNT_W = 22;
    localparam int TOL   = 4;
    localparam int LOCK  = 4;
    localparam int TMO   = 1000;

    localparam int S_IDLE = 0;
    localparam int S_WAIT = 1;
    localparam int S_MEAS = 2;
    localparam int S_LOCK = 3;

    typedef struct packed {
        logic             valid;
        logic             locked;
        logic             timeout;
        logic [CNT_W-1:0] period;
    } outs_t;

    typedef struct {
        int    due;
        string tag;
        outs_t o;
    } item_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b0;
    logic             tone = 1'b0;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             locked;
    logic             timeout;

    item_t q[$];
    outs_t hold;
    outs_t zero;
    int    cyc;
    int    last_tog;
    int    vecs;
    int    errs;

    int m_state;
    int m_prev;
    int m_match;
    int m_period;
    bit m_have;
    bit m_locked;
    bit m_timeout;

    tone_period_meter #(
        .CNT_W         (CNT_W),
        .TOL           (TOL),
        .LOCK_CNT      (LOCK),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .en_i     (en),
        .tone_i   (tone),
        .period_o (period),
        .valid_o  (valid),
        .locked_o (locked),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic cmp(input string tag, input outs_t exp);
        outs_t obs;
        obs.valid   = valid;
        obs.locked  = locked;
        obs.timeout = timeout;
        obs.period  = period;
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d: observed v=%0b l=%0b t=%0b p=%0d, expected v=%0b l=%0b t=%0b p=%0d",
                   tag, cyc, obs.valid, obs.locked, obs.timeout, obs.period,
                   exp.valid, exp.locked, exp.timeout, exp.period);
        end
    endtask

    task automatic model_disable();
        m_state   = S_IDLE;
        m_prev    = 0;
        m_match   = 0;
        m_period  = 0;
        m_have    = 1'b0;
        m_locked  = 1'b0;
        m_timeout = 1'b0;
    endtask

    task automatic model_enable();
        m_state = S_WAIT;
    endtask

    task automatic model_outs(input bit v, output outs_t e);
        e.valid   = v;
        e.locked  = m_locked;
        e.timeout = m_timeout;
        e.period  = CNT_W'(m_period);
    endtask

    task automatic model_timeout(output outs_t e);
        m_timeout = 1'b1;
        m_locked  = 1'b0;
        m_period  = 0;
        m_match   = 0;
        m_state   = S_WAIT;
        model_outs(1'b0, e);
    endtask

    task automatic model_edge(input int d, output outs_t e);
        bit v;
        v = 1'b0;
        m_timeout = 1'b0;
        case (m_state)
            S_WAIT: begin
                m_state = S_MEAS;
                m_have  = 1'b0;
                m_match = 0;
            end
            S_MEAS: begin
                if (m_have && absd(d, m_prev) <= TOL) begin
                    m_match++;
                    if (m_match == LOCK) begin
                        m_state  = S_LOCK;
                        m_locked = 1'b1;
                        m_period = d;
                        v        = 1'b1;
                    end
                end else begin
                    m_match = 0;
                end
                m_prev = d;
                m_have = 1'b1;
            end
            S_LOCK: begin
                if (absd(d, m_prev) <= TOL) begin
                    m_period = d;
                    v        = 1'b1;
                end else begin
                    m_locked = 1'b0;
                    m_match  = 0;
                    m_state  = S_MEAS;
                end
                m_prev = d;
            end
            default: ;
        endcase
        model_outs(v, e);
    endtask

    task automatic tick();
        item_t it;
        outs_t exp;
        string tag;
        @(posedge clk);
        #1;
        cyc++;
        tag = "hold";
        exp = hold;
        if (q.size() > 0 && q[0].due == cyc) begin
            it         = q.pop_front();
            exp        = it.o;
            tag        = it.tag;
            hold       = it.o;
            hold.valid = 1'b0;
        end
        cmp(tag, exp);
    endtask

    task automatic push(input int due, input string tag, input outs_t e);
        item_t it;
        it.due = due;
        it.tag = tag;
        it.o   = e;
        q.push_back(it);
    endtask

    // A transition driven now is sampled at the next edge; its effect shows 4 checks later.
    task automatic do_toggle(input int d, input string tag);
        outs_t e;
        tone = ~tone;
        model_edge(d, e);
        push(cyc + 4, tag, e);
        last_tog = cyc;
    endtask

    task automatic tone_start(input int n, input string tag);
        repeat (n) tick();
        do_toggle(0, tag);
    endtask

    task automatic tone_gap(input int d, input string tag);
        outs_t e;
        if (d > TMO && (m_state == S_MEAS || m_state == S_LOCK)) begin
            model_timeout(e);
            push(last_tog + TMO + 4, "timeout", e);
        end
        repeat (last_tog + d - cyc) tick();
        do_toggle(d, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        zero = '0;
        hold = '0;
        cyc  = 0;
        vecs = 0;
        errs = 0;
        model_disable();

        #1 rst_n = 1'b0;
        #2;
        cmp("reset_state", zero);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Constant 100-cycle tone: lock on the 6th edge, then track.
        en = 1'b1;
        model_enable();
        tone_start(5, "s1_start");
        for (int i = 0; i < 5; i++) tone_gap(100, "s1_acq");
        for (int i = 0; i < 3; i++) tone_gap(100, "s1_track");

        // Small step accepted, large step drops lock, relock, then the TOL boundary.
        tone_gap(103, "s2_step103");
        tone_gap(110, "s2_step110");
        for (int i = 0; i < 4; i++) tone_gap(110, "s2_relock");
        tone_gap(114, "s2_tol_in");
        tone_gap(119, "s2_tol_out");
        for (int i = 0; i < 4; i++) tone_gap(119, "s2_relock119");

        // Tone stops: timeout after 1000 cycles, cleared by the next edge.
        tone_gap(1500, "s3_resume");

        // Edges exactly 1000 cycles apart are measurements, not timeouts.
        for (int i = 0; i < 5; i++) tone_gap(1000, "s4_acq1000");
        tone_gap(1000, "s4_track1000");

        // Disable while locked, then re-enable: first edge only starts timing.
        repeat (50) tick();
        en = 1'b0;
        model_disable();
        push(cyc + 1, "s5_disable", zero);
        repeat (10) tick();
        en = 1'b1;
        model_enable();
        tone_start(20, "s5_start");
        for (int i = 0; i < 5; i++) tone_gap(100, "s5_acq");

        // Asynchronous reset between clock edges in the middle of a measurement.
        tone_gap(100, "s6_pre");
        repeat (30) tick();
        #3 rst_n = 1'b0;
        tone = 1'b0;
        #2;
        cmp("s6_async_reset", zero);
        q.delete();
        hold = zero;
        model_disable();
        model_enable();
        repeat (3) tick();
        rst_n = 1'b1;
        tone_start(10, "s6_start");
        for (int i = 0; i < 5; i++) tone_gap(100, "s6_acq");
        for (int i = 0; i < 2; i++) tone_gap(100, "s6_track");

        repeat (10) tick();
        vecs++;
        assert (q.size() === 0) else begin
            errs++;
            $error("FAIL queue_drain: observed %0d pending, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
